osc_pi_slew_ctrl: RTL and testbench

OSC_PI_SLEW_CTRL -- requirements
Module: osc_pi_slew_ctrl

---
 rtl/osc_pkg.sv | 17 +
 rtl/osc_pi_chan.sv | 62 ++++++
 rtl/osc_pi_slew_ctrl.sv | 128 ++++++++++++
 tb/tb_osc_pi_slew_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared types and default constants for the oscillator PI slew controller.
// Imported by the channel sub-module and the top level.
package osc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLEW  = 2'd1,
        ST_GUARD = 2'd2
    } osc_slew_state_t;

    localparam int OSC_NPH_DEF        = 5;
    localparam int OSC_CODE_W_DEF     = 4;
    localparam int OSC_DIV_W_DEF      = 8;
    localparam int OSC_SETTLE_CYC_DEF = 4;
    localparam int OSC_GRD_W          = 8;

endpackage

// File: rtl/osc_pi_chan.sv
// One phase channel: target/current codes, one-LSB slew toward target,
// registered left/right PI codes and settled flag.
module osc_pi_chan
    import osc_pkg::*;
#(
    parameter int CODE_W = OSC_CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              tick,
    output logic [CODE_W-1:0] pi_l,
    output logic [CODE_W-1:0] pi_r,
    output logic              settled
);

    logic [CODE_W-1:0] tgt_q, tgt_d;
    logic [CODE_W-1:0] cur_q, cur_d;
    logic [CODE_W-1:0] pir_q, pir_d;
    logic              settled_q, settled_d;

    always_comb begin
        tgt_d = tgt_q;
        cur_d = cur_q;
        if (en) begin
            if (wr) begin
                tgt_d = wr_code;
            end
            // Step against the old target so a coincident write waits a tick.
            if (tick) begin
                if (cur_q < tgt_q) begin
                    cur_d = cur_q + 1'b1;
                end else if (cur_q > tgt_q) begin
                    cur_d = cur_q - 1'b1;
                end
            end
        end
        pir_d     = ~cur_d;
        settled_d = (cur_d == tgt_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q     <= '0;
            cur_q     <= '0;
            pir_q     <= '1;
            settled_q <= 1'b1;
        end else begin
            tgt_q     <= tgt_d;
            cur_q     <= cur_d;
            pir_q     <= pir_d;
            settled_q <= settled_d;
        end
    end

    assign pi_l    = cur_q;
    assign pi_r    = pir_q;
    assign settled = settled_q;

endmodule

// File: rtl/osc_pi_slew_ctrl.sv
// Multi-channel PI slew controller: update handshake, step tick divider,
// IDLE/SLEW/GUARD sequencing and a sticky bad-index flag.
module osc_pi_slew_ctrl
    import osc_pkg::*;
#(
    parameter int NPH        = OSC_NPH_DEF,
    parameter int CODE_W     = OSC_CODE_W_DEF,
    parameter int DIV_W      = OSC_DIV_W_DEF,
    parameter int SETTLE_CYC = OSC_SETTLE_CYC_DEF,
    localparam int PH_W      = (NPH > 1) ? $clog2(NPH) : 1
) (
    input  logic                  ref_clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [PH_W-1:0]       upd_phase,
    input  logic [CODE_W-1:0]     upd_code,
    input  logic [DIV_W-1:0]      step_div,
    output logic [NPH*CODE_W-1:0] pi_l,
    output logic [NPH*CODE_W-1:0] pi_r,
    output logic [NPH-1:0]        settled,
    output logic                  busy,
    output logic                  done,
    output logic                  idx_err
);

    osc_slew_state_t       state_q, state_d;
    logic [DIV_W-1:0]      cnt_q, cnt_d;
    logic [OSC_GRD_W-1:0]  grd_q, grd_d;
    logic                  idx_err_q, idx_err_d;
    logic                  done_c;
    logic                  xfer;
    logic                  in_range;
    logic                  tick;
    logic                  all_set;
    logic [31:0]           phase_ext;
    logic [NPH-1:0]        wr_vec;

    assign upd_ready = en;
    assign xfer      = upd_valid && en;
    assign phase_ext = 32'(upd_phase);
    assign in_range  = phase_ext < 32'(NPH);
    assign tick      = (state_q == ST_SLEW) && (cnt_q == step_div);
    assign all_set   = &settled;

    for (genvar i = 0; i < NPH; i++) begin : g_ch
        assign wr_vec[i] = xfer && in_range && (phase_ext == 32'(i));

        osc_pi_chan #(
            .CODE_W (CODE_W)
        ) u_ch (
            .clk     (ref_clk),
            .rst     (rst),
            .en      (en),
            .wr      (wr_vec[i]),
            .wr_code (upd_code),
            .tick    (tick),
            .pi_l    (pi_l[i*CODE_W +: CODE_W]),
            .pi_r    (pi_r[i*CODE_W +: CODE_W]),
            .settled (settled[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grd_d     = grd_q;
        idx_err_d = idx_err_q;
        done_c    = 1'b0;
        if (en) begin
            if (xfer && !in_range) begin
                idx_err_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (!all_set) begin
                        state_d = ST_SLEW;
                    end
                end
                ST_SLEW: begin
                    // Wraps without ticking if step_div shrank below the count.
                    cnt_d = (cnt_q >= step_div) ? '0 : cnt_q + 1'b1;
                    if (all_set) begin
                        state_d = ST_GUARD;
                        grd_d   = OSC_GRD_W'(SETTLE_CYC - 1);
                        cnt_d   = '0;
                    end
                end
                ST_GUARD: begin
                    cnt_d = '0;
                    if (!all_set) begin
                        state_d = ST_SLEW;
                    end else if (grd_q == '0) begin
                        state_d = ST_IDLE;
                        done_c  = 1'b1;
                    end else begin
                        grd_d = grd_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            grd_q     <= '0;
            idx_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grd_q     <= grd_d;
            idx_err_q <= idx_err_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_c;
    assign idx_err = idx_err_q;

endmodule

// File: tb/tb_osc_pi_slew_ctrl.sv
// Directed bench for osc_pi_slew_ctrl with default parameters.
// Expected step values and spacings are queued at stimulus time.
module tb_osc_pi_slew_ctrl;

    localparam int NPH = 5;
    localparam int CW  = 4;
    localparam int DW  = 8;
    localparam int SC  = 4;

    logic              ref_clk = 1'b0;
    logic              rst;
    logic              en;
    logic              upd_valid;
    logic              upd_ready;
    logic [2:0]        upd_phase;
    logic [CW-1:0]     upd_code;
    logic [DW-1:0]     step_div;
    logic [NPH*CW-1:0] pi_l;
    logic [NPH*CW-1:0] pi_r;
    logic [NPH-1:0]    settled;
    logic              busy;
    logic              done;
    logic              idx_err;

    int tests = 0;
    int fails = 0;
    int done_total = 0;

    always #5 ref_clk = ~ref_clk;

    always @(negedge ref_clk) begin
        if (done === 1'b1) done_total++;
    end

    osc_pi_slew_ctrl #(
        .NPH        (NPH),
        .CODE_W     (CW),
        .DIV_W      (DW),
        .SETTLE_CYC (SC)
    ) dut (
        .ref_clk   (ref_clk),
        .rst       (rst),
        .en        (en),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_phase (upd_phase),
        .upd_code  (upd_code),
        .step_div  (step_div),
        .pi_l      (pi_l),
        .pi_r      (pi_r),
        .settled   (settled),
        .busy      (busy),
        .done      (done),
        .idx_err   (idx_err)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] lch(int c);
        return pi_l[c*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] rch(int c);
        return pi_r[c*CW +: CW];
    endfunction

    task automatic cyc();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic wr(int ph, int code);
        upd_valid = 1'b1;
        upd_phase = 3'(ph);
        upd_code  = 4'(code);
        cyc();
        upd_valid = 1'b0;
    endtask

    task automatic wait_ch(int c, int v, int lim, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < lim; n++) begin
            cyc();
            if (int'(lch(c)) == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(int lim, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < lim; n++) begin
            cyc();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int q_val[$];
        int q_gap[$];
        int t, last, st, dt, d0, ev, eg, bad, prev;
        bit ok;
        logic [NPH*CW-1:0] snap_l, snap_r;
        logic [NPH-1:0]    snap_s;

        rst = 1'b1; en = 1'b1; upd_valid = 1'b0;
        upd_phase = '0; upd_code = '0; step_div = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        check("rst_pil", 32'(pi_l), 32'h0);
        check("rst_pir", 32'(pi_r), 32'hFFFFF);
        check("rst_settled", 32'(settled), 32'h1F);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_idx_err", 32'(idx_err), 32'h0);
        check("rst_ready", 32'(upd_ready), 32'h1);

        // ch2 -> 5 with step_div 3: first step 5 cycles after write, then every 4
        step_div = 8'd3;
        for (int k = 1; k <= 5; k++) begin
            q_val.push_back(k);
            q_gap.push_back(k == 1 ? 5 : 4);
        end
        d0 = done_total;
        wr(2, 5);
        t = 0; last = 0; prev = 0; st = -1; dt = -1;
        for (int n = 0; n < 80; n++) begin
            cyc(); t++;
            if (int'(lch(2)) != prev) begin
                if (q_val.size() > 0) begin
                    ev = q_val.pop_front();
                    eg = q_gap.pop_front();
                end else begin
                    ev = -1; eg = -1;
                end
                check("t2_step_val", 32'(lch(2)), 32'(ev));
                check("t2_step_gap", 32'(t - last), 32'(eg));
                last = t;
                prev = int'(lch(2));
            end
            if (st < 0 && settled[2]) st = t;
            if (dt < 0 && done) dt = t;
            if (dt >= 0 && !busy) break;
        end
        check("t2_queue_left", 32'(q_val.size()), 32'd0);
        check("t2_pir", 32'(rch(2)), 32'd10);
        check("t2_done_lat", 32'(dt - st), 32'(SC));
        check("t2_done_cnt", 32'(done_total - d0), 32'd1);
        check("t2_busy_end", 32'(busy), 32'h0);

        // ch0 -> 15, retarget to 0 when cur=7; the coincident tick still lands 8
        step_div = 8'd0;
        d0 = done_total;
        wr(0, 15);
        wait_ch(0, 7, 40, ok);
        check("t3_reach7", 32'(ok), 32'h1);
        wr(0, 0);
        check("t3_peak", 32'(lch(0)), 32'd8);
        prev = int'(lch(0)); bad = 0;
        for (int n = 0; n < 60; n++) begin
            cyc();
            if (int'(lch(0)) != prev) begin
                if (int'(lch(0)) != prev - 1) bad++;
                prev = int'(lch(0));
            end
            if (!busy) break;
        end
        check("t3_bad_steps", 32'(bad), 32'd0);
        check("t3_final", 32'(lch(0)), 32'd0);
        check("t3_pir", 32'(rch(0)), 32'hF);
        check("t3_done_cnt", 32'(done_total - d0), 32'd1);

        // retarget ch4 while in GUARD: done only SETTLE_CYC after ch4 settles
        wr(0, 2);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            cyc();
            if (busy && settled == 5'h1F) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_reach_guard", 32'(ok), 32'h1);
        cyc();
        d0 = done_total;
        wr(4, 3);
        t = 0; st = -1; dt = -1; bad = 0;
        for (int n = 0; n < 60; n++) begin
            cyc(); t++;
            if (dt < 0 && !busy) bad++;
            if (st < 0 && settled[4]) st = t;
            if (dt < 0 && done) dt = t;
            if (dt >= 0 && !busy) break;
        end
        check("t4_idle_early", 32'(bad), 32'd0);
        check("t4_done_lat", 32'(dt - st), 32'(SC));
        check("t4_done_cnt", 32'(done_total - d0), 32'd1);
        check("t4_ch4", 32'(lch(4)), 32'd3);

        // out-of-range index
        snap_l = pi_l;
        wr(6, 9);
        cyc(); cyc();
        check("t5_idx_err", 32'(idx_err), 32'h1);
        check("t5_pil_same", 32'(pi_l), 32'(snap_l));
        check("t5_settled", 32'(settled), 32'h1F);
        check("t5_busy", 32'(busy), 32'h0);

        // freeze with en low mid-slew, then resume
        step_div = 8'd1;
        wr(3, 12);
        wait_ch(3, 4, 40, ok);
        check("t6_reach4", 32'(ok), 32'h1);
        en = 1'b0;
        upd_valid = 1'b1; upd_phase = 3'd1; upd_code = 4'd7;
        snap_l = pi_l; snap_r = pi_r; snap_s = settled;
        #1;
        check("t6_ready_low", 32'(upd_ready), 32'h0);
        bad = 0;
        for (int n = 0; n < 10; n++) begin
            cyc();
            if (pi_l !== snap_l || pi_r !== snap_r || settled !== snap_s) bad++;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        check("t6_frozen", 32'(bad), 32'd0);
        upd_valid = 1'b0;
        en = 1'b1;
        t = 0;
        for (int n = 0; n < 20; n++) begin
            cyc(); t++;
            if (lch(3) != 4'd4) break;
        end
        check("t6_resume_gap", 32'(t), 32'd2);
        check("t6_resume_val", 32'(lch(3)), 32'd5);
        wait_idle(60, ok);
        check("t6_idle", 32'(ok), 32'h1);
        check("t6_final_l", 32'(lch(3)), 32'd12);
        check("t6_final_r", 32'(rch(3)), 32'd3);
        check("t6_ch1_untouched", 32'(lch(1)), 32'd0);
        check("t6_idx_err_held", 32'(idx_err), 32'h1);

        // reset mid-slew overrides a coincident transfer
        step_div = 8'd0;
        wr(1, 15);
        wait_ch(1, 9, 40, ok);
        check("t7_reach9", 32'(ok), 32'h1);
        d0 = done_total;
        rst = 1'b1;
        upd_valid = 1'b1; upd_phase = 3'd0; upd_code = 4'd5;
        cyc();
        check("t7_pil", 32'(pi_l), 32'h0);
        check("t7_pir", 32'(pi_r), 32'hFFFFF);
        check("t7_busy", 32'(busy), 32'h0);
        check("t7_done", 32'(done), 32'h0);
        check("t7_idx_err", 32'(idx_err), 32'h0);
        rst = 1'b0;
        upd_valid = 1'b0;
        for (int n = 0; n < 5; n++) cyc();
        check("t7_no_done", 32'(done_total - d0), 32'd0);
        check("t7_settled", 32'(settled), 32'h1F);
        check("t7_still_idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
